// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 5-byte command frames (SYNC, CMD, HI, LO, CHK) from a UART
// byte stream and updates the DRSSTC interrupter configuration registers.
//   clk_i        system clock
//   rst_i        asynchronous reset, active-high
//   rx_data_i    received byte, qualified by rx_valid_i
//   rx_valid_i   one-cycle byte strobe from the UART receiver
//   period_o     interrupter period in clk ticks
//   ontime_o     interrupter on-time in clk ticks
//   enable_o     interrupter output enable
//   cfg_update_o one-cycle pulse the cycle after any register write
//   frame_err_o  one-cycle pulse on bad checksum, unknown command or inter-byte timeout
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned TIMEOUT    = 48000,
  parameter logic [15:0] ONTIME_MAX = 16'd400,
  parameter logic [15:0] PERIOD_MIN = 16'd480,
  parameter logic [15:0] PERIOD_RST = 16'd48000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [15:0] period_o,
  output logic [15:0] ontime_o,
  output logic        enable_o,
  output logic        cfg_update_o,
  output logic        frame_err_o
);

  typedef enum logic [2:0] {StSync, StCmd, StHi, StLo, StChk} state_e;

  localparam logic [16:0] TimeoutVal  = 17'(TIMEOUT);
  localparam logic [16:0] TimeoutLast = 17'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [16:0] gap_q, gap_d;
  logic [15:0] period_q, period_d;
  logic [15:0] ontime_q, ontime_d;
  logic        enable_q, enable_d;
  logic        cfg_q, cfg_d;
  logic        err_q, err_d;

  logic        wr;
  logic [15:0] data_word;
  logic [15:0] new_period;
  logic [15:0] new_ontime;
  logic        new_enable;

  assign data_word = {hi_q, lo_q};

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    gap_d      = gap_q;
    period_d   = period_q;
    ontime_d   = ontime_q;
    enable_d   = enable_q;
    cfg_d      = 1'b0;
    err_d      = 1'b0;
    wr         = 1'b0;
    new_period = period_q;
    new_ontime = ontime_q;
    new_enable = enable_q;

    if (rx_valid_i) begin
      // A byte always wins over a coincident timeout.
      gap_d = '0;
      unique case (state_q)
        StSync: begin
          if (rx_data_i == SYNC_BYTE) state_d = StCmd;
        end
        StCmd: begin
          cmd_d   = rx_data_i;
          state_d = StHi;
        end
        StHi: begin
          hi_d    = rx_data_i;
          state_d = StLo;
        end
        StLo: begin
          lo_d    = rx_data_i;
          state_d = StChk;
        end
        StChk: begin
          state_d = StSync;
          if (rx_data_i == (cmd_q ^ hi_q ^ lo_q)) begin
            unique case (cmd_q)
              8'h01: begin
                wr         = 1'b1;
                new_period = (data_word < PERIOD_MIN) ? PERIOD_MIN : data_word;
              end
              8'h02: begin
                wr         = 1'b1;
                new_ontime = (data_word > ONTIME_MAX) ? ONTIME_MAX : data_word;
              end
              8'h03: begin
                wr         = 1'b1;
                new_enable = lo_q[0];
              end
              default: err_d = 1'b1;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = StSync;
      endcase
    end else if (state_q != StSync) begin
      if (gap_q >= TimeoutLast) begin
        gap_d   = TimeoutVal;
        state_d = StSync;
        err_d   = 1'b1;
      end else begin
        gap_d = gap_q + 17'd1;
      end
    end

    if (wr) begin
      // On-time may never reach the period; fall back to 50% duty.
      if (new_ontime >= new_period) new_ontime = new_period >> 1;
      period_d = new_period;
      ontime_d = new_ontime;
      enable_d = new_enable;
      cfg_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StSync;
      cmd_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      gap_q    <= '0;
      period_q <= PERIOD_RST;
      ontime_q <= '0;
      enable_q <= 1'b0;
      cfg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      gap_q    <= gap_d;
      period_q <= period_d;
      ontime_q <= ontime_d;
      enable_q <= enable_d;
      cfg_q    <= cfg_d;
      err_q    <= err_d;
    end
  end

  assign period_o     = period_q;
  assign ontime_o     = ontime_q;
  assign enable_o     = enable_q;
  assign cfg_update_o = cfg_q;
  assign frame_err_o  = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser. Two instances share one byte stream: dut0 uses the default
// parameters, dut1 raises ONTIME_MAX to 600 and shortens TIMEOUT to 40 cycles.
module tb_uart_cmd_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] period0, ontime0, period1, ontime1;
  logic        enable0, cfg0, err0, enable1, cfg1, err1;

  int errors = 0;
  int checks = 0;

  uart_cmd_parser u_dut0 (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .period_o     (period0),
    .ontime_o     (ontime0),
    .enable_o     (enable0),
    .cfg_update_o (cfg0),
    .frame_err_o  (err0)
  );

  uart_cmd_parser #(
    .TIMEOUT    (40),
    .ONTIME_MAX (16'd600)
  ) u_dut1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .period_o     (period1),
    .ontime_o     (ontime1),
    .enable_o     (enable1),
    .cfg_update_o (cfg1),
    .frame_err_o  (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: collects frame bytes and idle time per instance, applies frame rules.
  int         tmo [2] = '{48000, 40};
  int         omax[2] = '{400, 600};
  int         fcnt[2];
  logic [7:0] fbuf[2][5];
  int         idle[2];
  int         m_per[2], m_ont[2], m_en[2], m_cfg[2], m_err[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      fcnt[i] = 0;
      idle[i] = 0;
      m_per[i] = 48000;
      m_ont[i] = 0;
      m_en[i]  = 0;
      m_cfg[i] = 0;
      m_err[i] = 0;
    end
  endtask

  task automatic apply_frame(input int i);
    int cmd, hi, lo, chk, val, p, o, e;
    bit wrote;
    cmd = int'(fbuf[i][1]);
    hi  = int'(fbuf[i][2]);
    lo  = int'(fbuf[i][3]);
    chk = int'(fbuf[i][4]);
    val = hi * 256 + lo;
    p = m_per[i];
    o = m_ont[i];
    e = m_en[i];
    wrote = 1'b0;
    if (chk != (cmd ^ hi ^ lo)) begin
      m_err[i] = 1;
    end else if (cmd == 1) begin
      p = (val < 480) ? 480 : val;
      wrote = 1'b1;
    end else if (cmd == 2) begin
      o = (val > omax[i]) ? omax[i] : val;
      wrote = 1'b1;
    end else if (cmd == 3) begin
      e = lo % 2;
      wrote = 1'b1;
    end else begin
      m_err[i] = 1;
    end
    if (wrote) begin
      if (o >= p) o = p / 2;
      m_per[i] = p;
      m_ont[i] = o;
      m_en[i]  = e;
      m_cfg[i] = 1;
    end
  endtask

  task automatic model_tick(input logic v, input logic [7:0] b);
    for (int i = 0; i < 2; i++) begin
      m_cfg[i] = 0;
      m_err[i] = 0;
      if (v) begin
        idle[i] = 0;
        if (fcnt[i] != 0 || b == 8'hA5) begin
          fbuf[i][fcnt[i]] = b;
          fcnt[i]++;
        end
        if (fcnt[i] == 5) begin
          fcnt[i] = 0;
          apply_frame(i);
        end
      end else if (fcnt[i] != 0) begin
        idle[i]++;
        if (idle[i] == tmo[i]) begin
          fcnt[i] = 0;
          m_err[i] = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("dut0.period", int'(period0), m_per[0]);
    check("dut0.ontime", int'(ontime0), m_ont[0]);
    check("dut0.enable", int'(enable0), m_en[0]);
    check("dut0.cfg_update", int'(cfg0), m_cfg[0]);
    check("dut0.frame_err", int'(err0), m_err[0]);
    check("dut1.period", int'(period1), m_per[1]);
    check("dut1.ontime", int'(ontime1), m_ont[1]);
    check("dut1.enable", int'(enable1), m_en[1]);
    check("dut1.cfg_update", int'(cfg1), m_cfg[1]);
    check("dut1.frame_err", int'(err1), m_err[1]);
  endtask

  // One clock cycle: drive on the falling edge, model at the rising edge, sample 1 ns later.
  task automatic step(input logic v, input logic [7:0] b);
    @(negedge clk);
    rx_valid = v;
    rx_data  = b;
    @(posedge clk);
    model_tick(v, b);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] k);
    step(1'b1, 8'hA5);
    step(1'b1, c);
    step(1'b1, h);
    step(1'b1, l);
    step(1'b1, k);
  endtask

  typedef struct {
    logic [7:0] cmd, hi, lo, chk;
    int per, ont0, ont1, en, cfg, err;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{8'h02, 8'h01, 8'h2C, 8'h2F, 48000, 300, 300, 0, 1, 0};
    tbl[1]  = '{8'h02, 8'h03, 8'hE8, 8'hE9, 48000, 400, 600, 0, 1, 0};
    tbl[2]  = '{8'h01, 8'h00, 8'h10, 8'h11, 480,   400, 240, 0, 1, 0};
    tbl[3]  = '{8'h03, 8'h00, 8'h01, 8'h00, 480,   400, 240, 0, 0, 1};
    tbl[4]  = '{8'h03, 8'h00, 8'h01, 8'h02, 480,   400, 240, 1, 1, 0};
    tbl[5]  = '{8'h01, 8'h03, 8'hE8, 8'hEA, 1000,  400, 240, 1, 1, 0};
    tbl[6]  = '{8'h02, 8'h01, 8'h90, 8'h93, 1000,  400, 400, 1, 1, 0};
    tbl[7]  = '{8'h01, 8'h02, 8'h58, 8'h5B, 600,   400, 400, 1, 1, 0};
    tbl[8]  = '{8'h01, 8'h01, 8'hE0, 8'hE0, 480,   400, 400, 1, 1, 0};
    tbl[9]  = '{8'h02, 8'h01, 8'hF4, 8'hF7, 480,   400, 240, 1, 1, 0};
    tbl[10] = '{8'h01, 8'h03, 8'hE8, 8'hEA, 1000,  400, 240, 1, 1, 0};
    tbl[11] = '{8'h03, 8'h00, 8'h00, 8'h03, 1000,  400, 240, 0, 1, 0};
    tbl[12] = '{8'h07, 8'h00, 8'h00, 8'h07, 1000,  400, 240, 0, 0, 1};
    tbl[13] = '{8'h02, 8'h00, 8'h00, 8'h02, 1000,  0,   0,   0, 1, 0};
    tbl[14] = '{8'h03, 8'h00, 8'h01, 8'h02, 1000,  0,   0,   1, 1, 0};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    #2;
    check("reset.period", int'(period0), 48000);
    check("reset.ontime", int'(ontime0), 0);
    check("reset.enable", int'(enable0), 0);
    check("reset.cfg_update", int'(cfg0), 0);
    check("reset.frame_err", int'(err0), 0);
    #21;
    rst = 1'b0;

    // Noise before SYNC is silently ignored.
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    check("noise.frame_err", int'(err0), 0);

    // Frame table, back to back with no idle cycles.
    foreach (tbl[n]) begin
      send_frame(tbl[n].cmd, tbl[n].hi, tbl[n].lo, tbl[n].chk);
      check($sformatf("tbl%0d.period", n), int'(period0), tbl[n].per);
      check($sformatf("tbl%0d.ontime0", n), int'(ontime0), tbl[n].ont0);
      check($sformatf("tbl%0d.ontime1", n), int'(ontime1), tbl[n].ont1);
      check($sformatf("tbl%0d.enable", n), int'(enable0), tbl[n].en);
      check($sformatf("tbl%0d.cfg_update", n), int'(cfg0), tbl[n].cfg);
      check($sformatf("tbl%0d.frame_err", n), int'(err0), tbl[n].err);
    end
    step(1'b0, 8'h00);
    check("pulse_width.cfg_update", int'(cfg0), 0);

    // Asynchronous reset in the middle of a frame.
    step(1'b1, 8'hA5);
    step(1'b1, 8'h02);
    step(1'b1, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.period", int'(period0), 48000);
    check("async_rst.ontime", int'(ontime0), 0);
    check("async_rst.enable", int'(enable0), 0);
    check("async_rst.enable1", int'(enable1), 0);
    model_reset();
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    step(1'b1, 8'h2C);
    step(1'b1, 8'h2F);
    check("after_rst.ontime", int'(ontime0), 0);
    check("after_rst.cfg_update", int'(cfg0), 0);

    // Inter-byte timeout on dut0 at its full 48000-cycle limit.
    begin
      int  n;
      bit  seen;
      n = 0;
      seen = 1'b0;
      step(1'b1, 8'hA5);
      step(1'b1, 8'h01);
      while (n < 48010 && !seen) begin
        step(1'b0, 8'h00);
        n++;
        if (err0) seen = 1'b1;
      end
      check("timeout.cycles", n, 48000);
    end
    send_frame(8'h03, 8'h00, 8'h01, 8'h02);
    check("after_timeout.enable", int'(enable0), 1);

    // Byte arriving on the cycle dut1 would time out is accepted.
    step(1'b1, 8'hA5);
    step(1'b1, 8'h01);
    for (int i = 0; i < 39; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h02);
    check("race.frame_err1", int'(err1), 0);
    step(1'b1, 8'h00);
    step(1'b1, 8'h03);
    check("race.period1", int'(period1), 512);

    // Randomized frames with noise, corrupt checksums and gaps around dut1's timeout.
    for (int k = 0; k < 400; k++) begin
      logic [7:0] fr[5];
      int sel;
      if ($urandom_range(0, 7) == 0) step(1'b1, 8'($urandom_range(0, 255)));
      sel = $urandom_range(0, 4);
      fr[0] = 8'hA5;
      fr[1] = (sel < 3) ? 8'(sel + 1) : (sel == 3) ? 8'($urandom_range(0, 255)) : 8'h02;
      fr[2] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      fr[3] = 8'($urandom_range(0, 255));
      fr[4] = fr[1] ^ fr[2] ^ fr[3];
      if ($urandom_range(0, 5) == 0) fr[4] = fr[4] ^ 8'($urandom_range(1, 255));
      for (int b = 0; b < 5; b++) begin
        int g;
        g = ($urandom_range(0, 9) == 0) ? $urandom_range(35, 45) : $urandom_range(0, 2);
        for (int j = 0; j < g; j++) step(1'b0, 8'h00);
        step(1'b1, fr[b]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
